regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, two-read register file and adds a second write port for the memory/late writeback path. It also adds a configurable number of read ports, a sequential clear engine and a registered debug tap. Register 0 is hardwired to zero. All state updates on the rising edge of `clk`.

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: register count; power of two, at least 4. Localparam `AW = $clog2(NREGS)`.
- `NRD`, 2: number of read ports, 1 to 4.
- `DBG_W`, 16: debug tap width; must not exceed `XLEN`.

Ports:
- `clk` input 1: clock; all state on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `rd_addr` input `NRD*AW`: read addresses; port k occupies bits `[k*AW +: AW]`.
- `rd_data` output `NRD*XLEN`: read data; port k occupies bits `[k*XLEN +: XLEN]`.
- `wa_we` input 1: write port A enable (early writeback).
- `wa_addr` input `AW`: write port A address.
- `wa_data` input `XLEN`: write port A data.
- `wb_we` input 1: write port B enable (late writeback).
- `wb_addr` input `AW`: write port B address.
- `wb_data` input `XLEN`: write port B data.
- `clr_req` input 1: pulse that starts a sequential clear of registers 1 to `NREGS-1`.
- `clr_busy` output 1: high while the clear engine runs.
- `dbg_sel` input `AW`: debug register select.
- `dbg_out` output `DBG_W`: registered low `DBG_W` bits of the selected register.

## Operation
- Reads are combinational. An address of 0 always returns 0.
- Writes to address 0 are discarded on both ports.
- If both ports write the same nonzero address in one cycle, port B wins.
- Clear engine FSM states:
  - `IDLE`: on `clr_req`, load `idx=1` and go to `CLEAR`.
  - `CLEAR`: each cycle write 0 to `regs[idx]`, then increment `idx`. When `idx==NREGS-1` is cleared, return to `IDLE`.
- `clr_busy` is high exactly in `CLEAR`.
- `clr_req` while in `CLEAR` is ignored; the engine does not restart.
- A port A or B write to the current `idx` in the same cycle overrides the clear. The write data is stored.
- Writes to already-cleared or not-yet-reached indices proceed normally. A not-yet-reached index is later zeroed by the engine.
- `dbg_out` is registered every cycle from the post-bypass value of `regs[dbg_sel][DBG_W-1:0]`.

## Timing
- `reset` has priority over all other activity:
  - all registers go to 0;
  - FSM goes to `IDLE`, `idx` to 1;
  - `clr_busy` goes to 0, `dbg_out` to 0.
- Reset mid-clear aborts the clear and leaves every register at 0.
- Write latency: data is stored at the rising edge where the enable is sampled.
- Read latency: 0 cycles. Bypass behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- Clear duration:
  - `clr_busy` rises the cycle after `clr_req` is sampled.
  - It stays high for exactly `NREGS-1` cycles.
  - It falls the cycle after register `NREGS-1` is zeroed.
- `dbg_out` latency: 1 cycle after `dbg_sel` or the register content changes.
- While a write is pending in the same cycle, reads of the target address during `CLEAR` follow the same bypass rule as normal reads.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-first forwarding. A read whose address matches an active nonzero write in the same cycle returns that write data; if both ports match, port B's data is returned. A read of `idx` during `CLEAR` with no matching write returns 0.
- Undefined: read-before-write. Reads return stored contents only, and new data becomes visible the cycle after the write. Needed by the pipeline only when the hazard unit stalls for writeback.

## Test plan
- Reset, then write 0xDEADBEEF to x5 via port A; read x5 and x0 on both ports. Next cycle x5 = 0xDEADBEEF and x0 = 0. A write of 0x1234 to x0 leaves x0 reading 0.
- Same cycle, A writes x7 = 0x11 and B writes x7 = 0x22. x7 = 0x22 after the edge. With `REGFILE_BYPASS_EN`, a same-cycle read of x7 returns 0x22; without it, the same-cycle read returns the old value.
- Fill x1 to x31 with their index, then pulse `clr_req`. `clr_busy` is high for 31 cycles. On cycle 10 of the clear, B writes x20 = 0xAA; x20 reads 0 after the clear. On the cycle `idx`=25, A writes x25 = 0x55; x25 = 0x55 at the end, all others 0.
- Assert `reset` on cycle 5 of a clear. `clr_busy` is 0 the next cycle, and all registers and `dbg_out` read 0. A second `clr_req` during `CLEAR` does not extend `clr_busy` beyond 31 cycles.
- Set x3 = 0x0001ABCD and `dbg_sel`=3. `dbg_out` = 0xABCD one cycle later with `DBG_W`=16. Changing `dbg_sel` to 0 gives 0x0000 on the next cycle.
- Parameter sweep with `NREGS`=8, `NRD`=4, `XLEN`=64: four ports read distinct registers simultaneously and return the correct values, and the clear lasts 7 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file.
//
// Two write ports (A = early writeback, B = late writeback, B wins on a
// same-address collision), NRD combinational read ports, a sequential clear
// engine that zeroes registers 1..NREGS-1 one per cycle, and a registered
// debug tap. Register 0 is hardwired to zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> write-first forwarding on all reads (and the debug tap)
//   undefined -> read-before-write, stored contents only
//
// Ports:
//   clk       clock, all state on the rising edge
//   reset     synchronous, active-high
//   rd_addr   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data   NRD packed read data, port k at [k*XLEN +: XLEN]
//   wa_*      write port A (enable, address, data)
//   wb_*      write port B (enable, address, data)
//   clr_req   pulse starting a sequential clear
//   clr_busy  high while the clear engine runs
//   dbg_sel   debug register select
//   dbg_out   registered low DBG_W bits of the selected register
//
// Parameter limits: NREGS a power of two >= 4, NRD in 1..4, DBG_W <= XLEN.

module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int DBG_W = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    input  logic                  wa_we,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_we,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic [AW-1:0]         dbg_sel,
    output logic [DBG_W-1:0]      dbg_out
);

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;

    clr_state_t       state;
    logic [AW-1:0]    idx;
    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  dbg_full;

    // Value a read of 'addr' observes this cycle. With forwarding, port B
    // is applied last so it wins a collision, and the register the clear
    // engine is about to zero already reads as 0 unless a write overrides it.
    function automatic logic [XLEN-1:0] read_value(input logic [AW-1:0] addr);
        logic [XLEN-1:0] v;
        v = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (state == CLEAR && addr == idx) v = '0;
        if (wa_we && wa_addr == addr) v = wa_data;
        if (wb_we && wb_addr == addr) v = wb_data;
`endif
        if (addr == '0) v = '0;
        return v;
    endfunction

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd_data[k*XLEN +: XLEN] = read_value(rd_addr[k*AW +: AW]);
    end

    assign dbg_full = read_value(dbg_sel);
    assign clr_busy = (state == CLEAR);

    // Register array. The clear write comes first so that a port write to
    // the same index in the same cycle overrides it; port B is last so it
    // wins over port A. Address 0 is never written and stays 0 from reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end
            if (wa_we && wa_addr != '0) begin
                regs[wa_addr] <= wa_data;
            end
            if (wb_we && wb_addr != '0) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    // Clear engine: walks idx from 1 to NREGS-1, one register per cycle.
    // A request arriving while a clear is running is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= AW'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= AW'(1);
                    end
                end
                CLEAR: begin
                    if (idx == AW'(NREGS - 1)) begin
                        state <= IDLE;
                        idx   <= AW'(1);
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= AW'(1);
                end
            endcase
        end
    end

    // Debug tap samples the same view a read port would see this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_out <= '0;
        end else begin
            dbg_out <= DBG_W'(dbg_full);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp.
//
// A main instance (default parameters) is driven by directed scenarios and
// random traffic and compared every cycle against a behavioural model: an
// array of register values plus a queue of indices still waiting to be
// cleared. A second instance (NREGS=8, NRD=4, XLEN=64) covers the parameter
// sweep. Honours REGFILE_BYPASS_EN the same way as the design.

module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int DBG_W = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic                 wa_we, wb_we;
    logic [AW-1:0]        wa_addr, wb_addr;
    logic [XLEN-1:0]      wa_data, wb_data;
    logic                 clr_req;
    logic                 clr_busy;
    logic [AW-1:0]        dbg_sel;
    logic [DBG_W-1:0]     dbg_out;

    // Sweep instance signals
    logic [11:0]          rd_addr2;
    logic [255:0]         rd_data2;
    logic                 wa_we2 = 1'b0, wb_we2 = 1'b0;
    logic [2:0]           wa_addr2 = '0, wb_addr2 = '0;
    logic [63:0]          wa_data2 = '0, wb_data2 = '0;
    logic                 clr_req2 = 1'b0;
    logic                 clr_busy2;
    logic [2:0]           dbg_sel2 = '0;
    logic [15:0]          dbg_out2;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .dbg_sel(dbg_sel), .dbg_out(dbg_out)
    );

    regfile_mp #(.XLEN(64), .NREGS(8), .NRD(4), .DBG_W(16)) dut2 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wa_we(wa_we2), .wa_addr(wa_addr2), .wa_data(wa_data2),
        .wb_we(wb_we2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .clr_req(clr_req2), .clr_busy(clr_busy2),
        .dbg_sel(dbg_sel2), .dbg_out(dbg_out2)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [XLEN-1:0]  model [NREGS];
    int               pending[$];
    logic [DBG_W-1:0] expDbg;
    logic [63:0]      m2 [8];

    int vectors = 0;
    int miscompares = 0;
    int busySeen = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // What a read of addr should return in the current cycle.
    function automatic logic [XLEN-1:0] expRead(input logic [AW-1:0] addr);
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wb_we && wb_addr == addr) return wb_data;
        if (wa_we && wa_addr == addr) return wa_data;
        if (pending.size() != 0 && pending[0] == int'(addr)) return '0;
`endif
        return model[addr];
    endfunction

    task automatic idleInputs();
        reset   = 1'b0;
        wa_we   = 1'b0; wa_addr = '0; wa_data = '0;
        wb_we   = 1'b0; wb_addr = '0; wb_data = '0;
        clr_req = 1'b0;
    endtask

    // Checks the current cycle against the model, clocks once, then advances
    // the model by one edge. Inputs are already set by the caller.
    task automatic applyStimulus();
        logic [XLEN-1:0]  tmp;
        logic [DBG_W-1:0] dbgNext;
        int               t;
        #1;
        for (int k = 0; k < NRD; k++) begin
            checkOutput($sformatf("rd%0d x%0d", k, rd_addr[k*AW +: AW]),
                        64'(rd_data[k*XLEN +: XLEN]),
                        64'(expRead(rd_addr[k*AW +: AW])));
        end
        checkOutput("clr_busy", 64'(clr_busy), 64'(pending.size() != 0));
        checkOutput("dbg_out", 64'(dbg_out), 64'(expDbg));
        if (clr_busy) busySeen++;
        tmp = expRead(dbg_sel);
        dbgNext = tmp[DBG_W-1:0];
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
            pending.delete();
            expDbg = '0;
        end else begin
            if (pending.size() != 0) begin
                t = pending.pop_front();
                model[t] = '0;
            end else if (clr_req) begin
                for (int i = 1; i < NREGS; i++) pending.push_back(i);
            end
            if (wa_we && wa_addr != 0) model[wa_addr] = wa_data;
            if (wb_we && wb_addr != 0) model[wb_addr] = wb_data;
            expDbg = dbgNext;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [XLEN-1:0] sameCycle7;
        logic [AW-1:0]   ra0, ra1;
        int              busy2;

        // Power-up reset (register contents unknown before this edge)
        idleInputs();
        reset = 1'b1; rd_addr = '0; dbg_sel = '0;
        rd_addr2 = '0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        for (int i = 0; i < 8; i++) m2[i] = '0;
        pending.delete();
        expDbg = '0;
        applyStimulus();

        // Basic write/read and x0 behaviour
        idleInputs();
        wa_we = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        applyStimulus();
        idleInputs();
        rd_addr = {5'd0, 5'd5};
        #1;
        checkOutput("x5 port0", 64'(rd_data[31:0]), 64'h00000000DEADBEEF);
        checkOutput("x0 port1", 64'(rd_data[63:32]), 64'h0);
        applyStimulus();
        idleInputs();
        rd_addr = {5'd5, 5'd0};
        #1;
        checkOutput("x5 port1", 64'(rd_data[63:32]), 64'h00000000DEADBEEF);
        checkOutput("x0 port0", 64'(rd_data[31:0]), 64'h0);
        applyStimulus();
        idleInputs();
        wa_we = 1'b1; wa_addr = 5'd0; wa_data = 32'h1234;
        rd_addr = {5'd0, 5'd0};
        applyStimulus();
        idleInputs();
        #1;
        checkOutput("x0 after write", 64'(rd_data[31:0]), 64'h0);
        applyStimulus();

        // Same-address collision: B wins
        idleInputs();
        wa_we = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        rd_addr = {5'd7, 5'd7};
`ifdef REGFILE_BYPASS_EN
        sameCycle7 = 32'h22;
`else
        sameCycle7 = 32'h0;
`endif
        #1;
        checkOutput("x7 same cycle", 64'(rd_data[31:0]), 64'(sameCycle7));
        applyStimulus();
        idleInputs();
        rd_addr = {5'd7, 5'd7};
        #1;
        checkOutput("x7 after collision", 64'(rd_data[31:0]), 64'h22);
        applyStimulus();

        // Fill x1..x31 with their index, then clear with overlapping writes
        for (int i = 1; i < NREGS; i++) begin
            idleInputs();
            wa_we = 1'b1; wa_addr = AW'(i); wa_data = 32'(i);
            rd_addr = {AW'(i), AW'(i - 1)};
            applyStimulus();
        end
        idleInputs();
        clr_req = 1'b1;
        busySeen = 0;
        applyStimulus();
        for (int c = 1; c <= 34; c++) begin
            idleInputs();
            if (c == 10) begin wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'hAA; end
            if (c == 15) clr_req = 1'b1;
            if (c == 25) begin wa_we = 1'b1; wa_addr = 5'd25; wa_data = 32'h55; end
            rd_addr = {5'd20, AW'(c)};
            dbg_sel = AW'(c + 1);
            applyStimulus();
        end
        checkOutput("clr_busy cycles", 64'(busySeen), 64'd31);
        idleInputs();
        rd_addr = {5'd20, 5'd25};
        #1;
        checkOutput("x25 after clear", 64'(rd_data[31:0]), 64'h55);
        checkOutput("x20 after clear", 64'(rd_data[63:32]), 64'h0);
        applyStimulus();
        for (int i = 0; i < NREGS; i += 2) begin
            idleInputs();
            rd_addr = {AW'(i + 1), AW'(i)};
            applyStimulus();
        end

        // Reset in the middle of a clear
        for (int i = 2; i < 10; i++) begin
            idleInputs();
            wa_we = 1'b1; wa_addr = AW'(i); wa_data = $urandom | 32'h1;
            applyStimulus();
        end
        idleInputs();
        dbg_sel = 5'd9;
        clr_req = 1'b1;
        applyStimulus();
        for (int c = 1; c <= 5; c++) begin
            idleInputs();
            if (c == 5) reset = 1'b1;
            applyStimulus();
        end
        idleInputs();
        #1;
        checkOutput("busy after reset", 64'(clr_busy), 64'h0);
        checkOutput("dbg after reset", 64'(dbg_out), 64'h0);
        for (int i = 0; i < NREGS; i += 2) begin
            idleInputs();
            rd_addr = {AW'(i + 1), AW'(i)};
            #1;
            checkOutput($sformatf("x%0d after reset", i), 64'(rd_data[31:0]), 64'h0);
            checkOutput($sformatf("x%0d after reset", i + 1), 64'(rd_data[63:32]), 64'h0);
            applyStimulus();
        end

        // Debug tap
        idleInputs();
        dbg_sel = 5'd0;
        wa_we = 1'b1; wa_addr = 5'd3; wa_data = 32'h0001ABCD;
        applyStimulus();
        idleInputs();
        dbg_sel = 5'd3;
        applyStimulus();
        idleInputs();
        #1;
        checkOutput("dbg x3", 64'(dbg_out), 64'hABCD);
        dbg_sel = 5'd0;
        applyStimulus();
        idleInputs();
        #1;
        checkOutput("dbg x0", 64'(dbg_out), 64'h0);
        applyStimulus();

        // Random traffic with occasional clears and resets
        for (int n = 0; n < 400; n++) begin
            idleInputs();
            wa_we   = 1'($urandom_range(0, 1));
            wa_addr = AW'($urandom_range(0, NREGS - 1));
            wa_data = $urandom;
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
            wb_data = $urandom;
            clr_req = ($urandom_range(0, 39) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            ra0 = ($urandom_range(0, 2) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
            ra1 = ($urandom_range(0, 2) == 0) ? wb_addr : AW'($urandom_range(0, NREGS - 1));
            rd_addr = {ra1, ra0};
            dbg_sel = AW'($urandom_range(0, NREGS - 1));
            applyStimulus();
        end

        // Parameter sweep instance: NREGS=8, NRD=4, XLEN=64
        idleInputs();
        for (int i = 1; i < 8; i += 2) begin
            wa_we2 = 1'b1; wa_addr2 = 3'(i);     wa_data2 = {$urandom, $urandom};
            wb_we2 = 1'b1; wb_addr2 = 3'((i + 1) % 8); wb_data2 = {$urandom, $urandom};
            m2[i] = wa_data2;
            if (i + 1 < 8) m2[i + 1] = wb_data2;
            applyStimulus();
        end
        wa_we2 = 1'b0; wb_we2 = 1'b0;
        rd_addr2 = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("sweep rd%0d", k), rd_data2[k*64 +: 64], m2[2*k + 1]);
        applyStimulus();
        rd_addr2 = {3'd0, 3'd6, 3'd4, 3'd2};
        #1;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("sweep rd%0d", k), rd_data2[k*64 +: 64], m2[2*k + 2]);
        checkOutput("sweep rd3 x0", rd_data2[255:192], 64'h0);
        applyStimulus();
        clr_req2 = 1'b1;
        applyStimulus();
        clr_req2 = 1'b0;
        busy2 = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (clr_busy2) busy2++;
            applyStimulus();
        end
        checkOutput("sweep clear cycles", 64'(busy2), 64'd7);
        rd_addr2 = {3'd7, 3'd6, 3'd5, 3'd4};
        #1;
        checkOutput("sweep x4..x7 cleared", rd_data2, 256'h0);
        applyStimulus();
        rd_addr2 = {3'd3, 3'd2, 3'd1, 3'd0};
        #1;
        checkOutput("sweep x0..x3 cleared", rd_data2, 256'h0);
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
